// File: rtl/hs_stream_tx.sv
// Valid/ready burst source: emits len beats of an incrementing pattern from seed,
// with optional idle gaps between beats, while obeying downstream backpressure.
module hs_stream_tx #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned GAP_W  = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] seed,
  input  logic [GAP_W-1:0]  gap,
  input  logic              ready_down,
  output logic              valid_down,
  output logic [DATA_W-1:0] data_down,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t            state_q,     state_d;
  logic [LEN_W-1:0]  beat_cnt_q,  beat_cnt_d;
  logic [GAP_W-1:0]  gap_lat_q,   gap_lat_d;
  logic [GAP_W-1:0]  gap_cnt_q,   gap_cnt_d;
  logic              valid_q,     valid_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic handshake;

  // Handshake uses only the registered valid, so valid never depends on ready combinationally.
  assign handshake = valid_q && ready_down;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    gap_lat_d   = gap_lat_q;
    gap_cnt_d   = gap_cnt_q;
    valid_d     = valid_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start && (len != '0)) begin
          state_d     = ST_SEND;
          beat_cnt_d  = len;
          gap_lat_d   = gap;
          valid_d     = 1'b1;
          data_d      = seed;
          busy_d      = 1'b1;
          stall_cnt_d = '0;
        end
      end

      ST_SEND: begin
        if (handshake) begin
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
          if (beat_cnt_q == LEN_W'(1)) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (gap_lat_q == '0) begin
            data_d = data_q + DATA_W'(1);
          end else begin
            state_d   = ST_GAP;
            valid_d   = 1'b0;
            gap_cnt_d = gap_lat_q;
          end
        end else if (stall_cnt_q != '1) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = ST_SEND;
          valid_d = 1'b1;
          data_d  = data_q + DATA_W'(1);
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      gap_lat_q   <= '0;
      gap_cnt_q   <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      gap_lat_q   <= gap_lat_d;
      gap_cnt_q   <= gap_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign valid_down = valid_q;
  assign data_down  = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hs_stream_tx.sv
// Directed and randomised-backpressure checks for hs_stream_tx (DATA_W=3, LEN_W=8, GAP_W=4).
module tb_hs_stream_tx;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [7:0]  len;
  logic [2:0]  seed;
  logic [3:0]  gap;
  logic        ready_down;
  logic        valid_down;
  logic [2:0]  data_down;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hs_stream_tx #(.DATA_W(3), .LEN_W(8), .GAP_W(4)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .len        (len),
    .seed       (seed),
    .gap        (gap),
    .ready_down (ready_down),
    .valid_down (valid_down),
    .data_down  (data_down),
    .busy       (busy),
    .done       (done),
    .stall_cnt  (stall_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  logic [2:0] exp_basic [4];
  logic [6:0] exp_gap_valid;
  logic [2:0] exp_gap_data [3];
  logic [2:0] expd;
  logic [2:0] d;
  logic       v, r, fin;
  int         got, l, stalls, gi;

  initial begin
    exp_basic     = '{3'd6, 3'd7, 3'd0, 3'd1};
    exp_gap_valid = 7'b1001001;
    exp_gap_data  = '{3'd0, 3'd1, 3'd2};

    sys_rst = 1'b1; start = 1'b0; len = '0; seed = '0; gap = '0; ready_down = 1'b1;
    tick(); tick();
    chk("rst_valid", valid_down, 1'b0);
    chk("rst_data", data_down, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall_cnt, 16'd0);
    sys_rst = 1'b0;
    tick();

    // Basic burst len=4 seed=6 gap=0
    start = 1'b1; len = 8'd4; seed = 3'd6; gap = 4'd0; ready_down = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("basic_valid", valid_down, 1'b1);
      chk("basic_data", data_down, exp_basic[i]);
      chk("basic_nodone", done, 1'b0);
      chk("basic_busy", busy, 1'b1);
      tick();
    end
    chk("basic_done", done, 1'b1);
    chk("basic_done_busy", busy, 1'b1);
    chk("basic_done_valid", valid_down, 1'b0);
    chk("basic_stall", stall_cnt, 16'd0);
    tick();
    chk("basic_done_pulse", done, 1'b0);
    chk("basic_idle_busy", busy, 1'b0);

    // len=0 command is ignored
    start = 1'b1; len = 8'd0; seed = 3'd5;
    tick();
    start = 1'b0;
    chk("len0_valid", valid_down, 1'b0);
    chk("len0_busy", busy, 1'b0);
    tick();
    chk("len0_done", done, 1'b0);
    chk("len0_busy2", busy, 1'b0);

    // Backpressure: ready low for 3 cycles while beat 2 (data 3) is offered
    start = 1'b1; len = 8'd3; seed = 3'd2; gap = 4'd0; ready_down = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_b1", data_down, 3'd2);
    tick();
    ready_down = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", valid_down, 1'b1);
      chk("bp_hold_data", data_down, 3'd3);
      tick();
    end
    chk("bp_hold_valid", valid_down, 1'b1);
    chk("bp_hold_data", data_down, 3'd3);
    ready_down = 1'b1;
    tick();
    chk("bp_b3_valid", valid_down, 1'b1);
    chk("bp_b3", data_down, 3'd4);
    tick();
    chk("bp_done", done, 1'b1);
    chk("bp_stall", stall_cnt, 16'd3);
    tick();
    chk("bp_stall_hold", stall_cnt, 16'd3);

    // Gap=2, with conflicting start commands during SEND/GAP and DONE
    start = 1'b1; len = 8'd3; seed = 3'd0; gap = 4'd2; ready_down = 1'b1;
    tick();
    len = 8'd5; seed = 3'd5; gap = 4'd0;
    gi = 0;
    for (int i = 6; i >= 0; i--) begin
      chk("gap_valid", valid_down, exp_gap_valid[i]);
      if (exp_gap_valid[i]) begin
        chk("gap_data", data_down, exp_gap_data[gi]);
        gi++;
      end
      tick();
    end
    chk("gap_done", done, 1'b1);
    chk("gap_busy", busy, 1'b1);
    seed = 3'd7; len = 8'd2;
    tick();
    start = 1'b0;
    chk("gap_idle_valid", valid_down, 1'b0);
    chk("gap_idle_busy", busy, 1'b0);
    chk("gap_idle_done", done, 1'b0);
    tick();
    chk("gap_no2nd_valid", valid_down, 1'b0);
    chk("gap_no2nd_busy", busy, 1'b0);

    // Reset mid-burst, with start asserted alongside reset
    start = 1'b1; len = 8'd8; seed = 3'd1; gap = 4'd0; ready_down = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mr_data4", data_down, 3'd4);
    ready_down = 1'b0;
    tick();
    chk("mr_stall1", stall_cnt, 16'd1);
    sys_rst = 1'b1; start = 1'b1; len = 8'd2; seed = 3'd3;
    tick();
    sys_rst = 1'b0; start = 1'b0; ready_down = 1'b1;
    chk("mr_valid", valid_down, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_stall", stall_cnt, 16'd0);
    chk("mr_done", done, 1'b0);
    tick();
    chk("mr_done2", done, 1'b0);
    chk("mr_valid2", valid_down, 1'b0);
    start = 1'b1; len = 8'd2; seed = 3'd5;
    tick();
    start = 1'b0;
    chk("mr_fresh1", data_down, 3'd5);
    tick();
    chk("mr_fresh2", data_down, 3'd6);
    tick();
    chk("mr_fresh_done", done, 1'b1);
    tick();

    // Random backpressure soak with scoreboard
    for (int b = 0; b < 1000; b++) begin
      l = $urandom_range(1, 5);
      start = 1'b1; len = 8'(l); seed = 3'($urandom_range(0, 7)); gap = 4'($urandom_range(0, 2));
      ready_down = ($urandom_range(0, 3) != 0);
      expd = seed;
      tick();
      start = 1'b0;
      got = 0; stalls = 0; fin = 1'b0;
      for (int c = 0; c < 400 && !fin; c++) begin
        if (done) begin
          fin = 1'b1;
          chk("soak_count", got, l);
          chk("soak_stall", stall_cnt, stalls);
        end else begin
          v = valid_down; d = data_down; r = ready_down;
          if (v && r) begin
            chk("soak_data", d, expd);
            expd++;
            got++;
          end
          if (v && !r) stalls++;
          tick();
          if (v && !r) chk("soak_hold", {valid_down, data_down}, {1'b1, d});
          ready_down = ($urandom_range(0, 3) != 0);
        end
      end
      chk("soak_finished", fin, 1'b1);
      tick();
      chk("soak_idle", busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_stream_tx.md
# hs_stream_tx

Valid/ready stream transmitter: drives the upstream side of the `valid`/`ready`/`data` handshake used by the pipeline and skid-buffer stages. Software or a test sequencer issues a burst command (length, seed, inter-beat gap). The block emits an incrementing data pattern that fully obeys backpressure. It is the traffic source in front of the pipe stages and also serves as the stimulus generator for their benches.

## Interface
- `DATA_W`, default 3: data beat width; the pattern wraps modulo 2^DATA_W.
- `LEN_W`, default 8: width of the burst-length field.
- `GAP_W`, default 4: width of the inter-beat idle-gap field.
- `sys_clk` in 1: single clock; all logic is on the rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `start` in 1: burst command strobe; sampled only in IDLE.
- `len` in LEN_W: beats in the burst; 0 means the command is ignored.
- `seed` in DATA_W: data value of the first beat.
- `gap` in GAP_W: idle cycles (valid low) inserted after each accepted beat except the last.
- `ready_down` in 1: downstream ready.
- `valid_down` out 1: beat valid.
- `data_down` out DATA_W: beat data.
- `busy` out 1: high from command accept through the DONE cycle.
- `done` out 1: one-cycle pulse after the final beat is accepted.
- `stall_cnt` out 16: cycles in the current or last burst with `valid_down && !ready_down`; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, SEND, GAP, DONE. All outputs are registered.
- IDLE: when `start && len!=0` at an edge:
  - latch `len`, `seed` and `gap`;
  - clear `stall_cnt`;
  - set beat counter = `len`;
  - go to SEND with `valid_down`=1 and `data_down`=`seed`.
  - When `start && len==0`: no state change, no `done`.
- SEND: `valid_down`=1. A handshake (`valid_down && ready_down` at an edge) decrements the beat counter.
  - Last beat (counter==1): go to DONE, `valid_down`←0.
  - Otherwise, if latched gap==0: stay in SEND, `data_down`←`data_down`+1 (mod 2^DATA_W).
  - Otherwise: go to GAP, `valid_down`←0, gap counter←gap.
  - No handshake: `valid_down` and `data_down` hold; `stall_cnt` increments unless already 0xFFFF.
- GAP: `valid_down`=0. The gap counter decrements each cycle; on reaching 1, go to SEND with `data_down` = previous beat + 1.
- DONE: `done`=1 and `busy`=1 for exactly one cycle, then go to IDLE unconditionally. `start` is ignored in DONE.
- `start`, `len`, `seed` and `gap` are don't-care outside IDLE. Changing them mid-burst has no effect.
- Protocol invariants, always true outside reset:
  - once `valid_down` rises, it stays high and `data_down` stays stable until the handshake;
  - `valid_down` never depends combinationally on `ready_down`.
- `busy`=1 in SEND, GAP and DONE. `busy`=0 in IDLE.
- Width rules: `len` up to 2^LEN_W−1 beats; data increments wrap (for example 7→0 at DATA_W=3).

## Timing
- Reset (synchronous, takes effect at the edge with `sys_rst`=1): state IDLE, `valid_down`=0, `data_down`=0, `busy`=0, `done`=0, `stall_cnt`=0.
- Reset mid-burst: `valid_down` drops at that edge and the burst is abandoned. No `done` is produced.
- Reset has priority over `start` in the same cycle.
- Start-to-first-valid latency: 1 cycle. `valid_down`=1 in the cycle after the `start` edge.
- Throughput with gap=0 and `ready_down` held high: one beat per cycle. A burst of N beats occupies N SEND cycles plus 1 DONE cycle.
- Gap g>0: a beat is offered every g+1 cycles at minimum.
- `done` rises the cycle after the final handshake edge.
- Earliest next accepted `start` is the edge at the end of the cycle after DONE (IDLE cycle). Back-to-back bursts therefore have 2 dead cycles between the last beat and the next first beat.
- `stall_cnt` is valid from the DONE cycle onward and holds until the next accepted start.

## Test plan
- Basic burst: reset, then `start` with len=4, seed=6, gap=0, `ready_down`=1 → beats 6,7,0,1 on 4 consecutive cycles; `done` pulses once, 1 cycle after the 4th beat; `stall_cnt`=0.
- Backpressure: len=3, seed=2, gap=0, `ready_down` low for 3 cycles during beat 2 → data 3 held stable with valid high throughout; beats 2,3,4 received in order; `stall_cnt`=3.
- Gap: len=3, seed=0, gap=2, `ready_down`=1 → valid pattern 1,0,0,1,0,0,1; data 0,1,2; `done` asserted 1 cycle after the last beat.
- Ignored commands:
  - `start` with len=0 → no valid, no busy, no `done`;
  - `start` during SEND or DONE with different seed/len → current burst unchanged and no second burst starts.
- Reset mid-burst: len=8, reset asserted after the 3rd handshake → next cycle `valid_down`=0, `busy`=0, `stall_cnt`=0, no `done`; a fresh burst afterwards starts at its own seed.
- Random backpressure soak: 1000 bursts, random len/seed/gap/`ready_down` → scoreboard sees every beat exactly once in order, with no valid drop and no data change while stalled.
